sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one single-port 8-bit sprite/image RAM (1-cycle synchronous read, write-first) between three clients:
  - the VGA pixel fetcher (video);
  - the snake game logic (game);
  - a built-in fill engine that clears or paints an address range.
- Sits between the RAM instance and its clients in the display subsystem.
- Drives the RAM's en/we/addr/data_i and routes data_o back to the client that issued the read.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 16, RAM address width; address space 2^ADDR_WIDTH words.
- STARVE_LIMIT, 8, consecutive denied game cycles before game is forced ahead of video; 0 disables the guard.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- vid_req  in  1  video read request, single cycle, no retry.
- vid_addr  in  ADDR_WIDTH  video read address.
- vid_rvalid  out  1  video read data valid.
- vid_rdata  out  DATA_WIDTH  video read data.
- vid_miss  out  1  video request dropped this cycle.
- gm_req  in  1  game request; held until granted.
- gm_we  in  1  game write enable.
- gm_addr  in  ADDR_WIDTH  game address.
- gm_wdata  in  DATA_WIDTH  game write data.
- gm_gnt  out  1  game request accepted this cycle.
- gm_rvalid  out  1  game read data valid.
- gm_rdata  out  DATA_WIDTH  game read data.
- fill_start  in  1  start fill pulse.
- fill_base  in  ADDR_WIDTH  first fill address.
- fill_len  in  ADDR_WIDTH+1  number of words to fill.
- fill_value  in  DATA_WIDTH  fill data.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle completion pulse.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data.

Behaviour:
- Arbitration, combinational, evaluated every cycle.
  - Priority: video > game > fill.
  - Exception: when the starve counter equals STARVE_LIMIT (and STARVE_LIMIT != 0) and gm_req=1, game wins over video.
- Winner drives the RAM port the same cycle:
  - ram_en=1;
  - ram_we=0 for video; ram_we=gm_we for game; ram_we=1 for fill;
  - addr/wdata taken from the winner.
- No winner: ram_en=0, ram_we=0, addr/wdata hold 0.
- gm_gnt=1 in the cycle game wins. The game client holds req/we/addr/wdata stable until gnt.
- vid_miss=1 when vid_req=1 and video loses. The video request is not queued.
- Read return:
  - A registered 2-bit tag (NONE/VID/GM) records the read issued in cycle N.
  - In cycle N+1, vid_rvalid or gm_rvalid = 1 and the matching rdata = ram_rdata.
  - Writes and fill produce no rvalid.
  - rdata outputs are combinational pass-through of ram_rdata; they are meaningful only while rvalid=1.
- Starve counter:
  - Increments each cycle gm_req=1 and gm_gnt=0.
  - Saturates at STARVE_LIMIT.
  - Clears on gm_gnt or when gm_req=0.
- Fill FSM, states IDLE, RUN, DONE:
  - IDLE: fill_start=1 latches base, len, value.
    - len=0 -> DONE.
    - Otherwise -> RUN with fill_busy=1.
  - RUN: each cycle fill wins, it writes value at the current address, then increments the address (wraps modulo 2^ADDR_WIDTH) and decrements the remaining count.
    - After the last write -> DONE.
    - Cycles lost to video or game stall the fill; no write occurs and the state is unchanged.
  - DONE: fill_done=1 and fill_busy=0 for one cycle -> IDLE.
  - fill_start while busy or in DONE is ignored.
- Reset (async, any time):
  - All registered outputs 0, tag NONE, starve counter 0, FSM IDLE.
  - An in-flight fill is aborted with no fill_done.
  - A read issued in the cycle before reset returns no rvalid.
- Every cycle: at most one RAM access and at most one rvalid.

Decomposition:
- Shared display package holds:
  - RAM geometry constants (DATA_WIDTH=8, ADDR_WIDTH=16, RAM_SIZE=65536);
  - the read-tag enum (TAG_NONE, TAG_VID, TAG_GM);
  - the fill FSM state enum.
- One sub-module, sram_fill_engine: fill FSM, address/count registers, and fill_req/fill_ack handshake to the arbiter core.

Test Plan:
- Video read only: vid_req, addr 0x0010 in cycle 5, RAM preloaded 0x3C -> ram_en=1, ram_we=0 in cycle 5; vid_rvalid=1, vid_rdata=0x3C in cycle 6; gm_rvalid=0.
- Game write then read: gm write 0xA5 to 0x1234 (gnt same cycle), then gm read of 0x1234 -> gm_rvalid=1, gm_rdata=0xA5 one cycle after the read grant; no rvalid for the write.
- Starvation, STARVE_LIMIT=8: vid_req held high continuously, gm_req high from cycle 0 -> gm_gnt=0 for cycles 0-7; gm_gnt=1 and vid_miss=1 in cycle 8; counter back to 0.
- Fill wrap: base 0xFFFE, len 4, value 0x00, no other traffic -> writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001 on consecutive cycles; fill_done pulses exactly once, the cycle after the last write.
- Fill stall and edge cases:
  - fill len 3 with video requests interleaved every other cycle -> exactly 3 fill writes, in order, and no video misses;
  - fill_start during RUN is ignored;
  - len=0 -> fill_done the cycle after start, with no RAM writes.
- Reset mid-fill: assert reset two writes into len 10 -> fill_busy=0 immediately, no fill_done, ram_en=0; a new fill_start after reset runs normally.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared display-subsystem definitions: RAM geometry, read-return tags and
// fill engine states.
package sram_port_arbiter_pkg;

    localparam int RAM_DATA_WIDTH = 8;
    localparam int RAM_ADDR_WIDTH = 16;
    localparam int RAM_SIZE       = 65536;

    // Which client owns the data coming back from the RAM this cycle
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_GM   = 2'd2
    } rd_tag_e;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_RUN  = 2'd1,
        FILL_DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Client-side bus of the sprite RAM arbiter: video fetcher, game logic and
// fill control. master = client side, slave = arbiter side.
interface sram_port_arbiter_if
    import sram_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
);
    logic                  vid_req;
    logic [ADDR_WIDTH-1:0] vid_addr;
    logic                  vid_rvalid;
    logic [DATA_WIDTH-1:0] vid_rdata;
    logic                  vid_miss;

    logic                  gm_req;
    logic                  gm_we;
    logic [ADDR_WIDTH-1:0] gm_addr;
    logic [DATA_WIDTH-1:0] gm_wdata;
    logic                  gm_gnt;
    logic                  gm_rvalid;
    logic [DATA_WIDTH-1:0] gm_rdata;

    logic                  fill_start;
    logic [ADDR_WIDTH-1:0] fill_base;
    logic [ADDR_WIDTH:0]   fill_len;
    logic [DATA_WIDTH-1:0] fill_value;
    logic                  fill_busy;
    logic                  fill_done;

    modport master (
        output vid_req, vid_addr,
        input  vid_rvalid, vid_rdata, vid_miss,
        output gm_req, gm_we, gm_addr, gm_wdata,
        input  gm_gnt, gm_rvalid, gm_rdata,
        output fill_start, fill_base, fill_len, fill_value,
        input  fill_busy, fill_done
    );

    modport slave (
        input  vid_req, vid_addr,
        output vid_rvalid, vid_rdata, vid_miss,
        input  gm_req, gm_we, gm_addr, gm_wdata,
        output gm_gnt, gm_rvalid, gm_rdata,
        input  fill_start, fill_base, fill_len, fill_value,
        output fill_busy, fill_done
    );

endinterface

// File: rtl/sram_port_arbiter_fill.sv
// Fill engine: writes one value over an address range, one word per granted
// cycle, stalling whenever the arbiter gives the port to another client.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   FILL_IDLE | waiting for fill_start; parameters latched on start
//   FILL_RUN  | requesting the port; one write per fill_ack
//   FILL_DONE | one-cycle fill_done pulse, then back to idle
module sram_fill_engine
    import sram_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fill_start,
    input  logic [ADDR_WIDTH-1:0] fill_base,
    input  logic [ADDR_WIDTH:0]   fill_len,
    input  logic [DATA_WIDTH-1:0] fill_value,
    input  logic                  fill_ack,
    output logic                  fill_req,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [DATA_WIDTH-1:0] fill_wdata,
    output logic                  fill_busy,
    output logic                  fill_done
);

    fill_state_e           state;
    logic [ADDR_WIDTH:0]   remaining;

    assign fill_req = fill_busy;

    // Fill sequencing: latch on start, count remaining words down per ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FILL_IDLE;
            remaining  <= '0;
            fill_addr  <= '0;
            fill_wdata <= '0;
            fill_busy  <= 1'b0;
            fill_done  <= 1'b0;
        end else begin
            unique case (state)
                FILL_IDLE: begin
                    fill_done <= 1'b0;
                    if (fill_start) begin
                        fill_addr  <= fill_base;
                        remaining  <= fill_len;
                        fill_wdata <= fill_value;
                        if (fill_len == '0) begin
                            state     <= FILL_DONE;
                            fill_done <= 1'b1;
                        end else begin
                            state     <= FILL_RUN;
                            fill_busy <= 1'b1;
                        end
                    end
                end
                FILL_RUN: begin
                    if (fill_ack) begin
                        fill_addr <= fill_addr + ADDR_WIDTH'(1);
                        remaining <= remaining - (ADDR_WIDTH+1)'(1);
                        if (remaining == (ADDR_WIDTH+1)'(1)) begin
                            state     <= FILL_DONE;
                            fill_busy <= 1'b0;
                            fill_done <= 1'b1;
                        end
                    end
                end
                FILL_DONE: begin
                    fill_done <= 1'b0;
                    state     <= FILL_IDLE;
                end
                default: begin
                    state     <= FILL_IDLE;
                    fill_busy <= 1'b0;
                    fill_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port sprite RAM arbiter: video > game > fill, with a starvation
// guard that lets a long-waiting game request jump ahead of video. Read data
// is steered back to the requester one cycle later by a registered tag.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH   = RAM_ADDR_WIDTH,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    sram_port_arbiter_if.slave    bus,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    rd_tag_e               rd_tag;
    logic [SW-1:0]         starve_cnt;
    logic                  starve_hit;
    logic                  vid_win;
    logic                  gm_win;
    logic                  fill_req;
    logic                  fill_ack;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic [DATA_WIDTH-1:0] fill_wdata;

    sram_fill_engine #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fill (
        .clk        (clk),
        .reset      (reset),
        .fill_start (bus.fill_start),
        .fill_base  (bus.fill_base),
        .fill_len   (bus.fill_len),
        .fill_value (bus.fill_value),
        .fill_ack   (fill_ack),
        .fill_req   (fill_req),
        .fill_addr  (fill_addr),
        .fill_wdata (fill_wdata),
        .fill_busy  (bus.fill_busy),
        .fill_done  (bus.fill_done)
    );

    // Pick this cycle's winner and drive the RAM port from it
    always_comb begin
        starve_hit = (STARVE_LIMIT != 0) && (starve_cnt == SW'(STARVE_LIMIT)) && bus.gm_req;
        vid_win    = bus.vid_req && !starve_hit;
        gm_win     = bus.gm_req && !vid_win;
        fill_ack   = fill_req && !vid_win && !gm_win;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        if (vid_win) begin
            ram_en   = 1'b1;
            ram_addr = bus.vid_addr;
        end else if (gm_win) begin
            ram_en    = 1'b1;
            ram_we    = bus.gm_we;
            ram_addr  = bus.gm_addr;
            ram_wdata = bus.gm_wdata;
        end else if (fill_ack) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = fill_addr;
            ram_wdata = fill_wdata;
        end
    end

    assign bus.gm_gnt     = gm_win;
    assign bus.vid_miss   = bus.vid_req && !vid_win;
    assign bus.vid_rvalid = (rd_tag == TAG_VID);
    assign bus.gm_rvalid  = (rd_tag == TAG_GM);
    assign bus.vid_rdata  = ram_rdata;
    assign bus.gm_rdata   = ram_rdata;

    // Remember who issued this cycle's read so next cycle's data goes to them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_tag <= TAG_NONE;
        end else if (vid_win) begin
            rd_tag <= TAG_VID;
        end else if (gm_win && !bus.gm_we) begin
            rd_tag <= TAG_GM;
        end else begin
            rd_tag <= TAG_NONE;
        end
    end

    // Count consecutive denied game cycles, saturating at the limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!bus.gm_req || gm_win) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural write-first RAM.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;
    logic [7:0]  mem [0:65535];

    int vectors = 0;
    int miscompares = 0;

    sram_port_arbiter_if bus ();

    sram_port_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                ram_rdata     <= ram_wdata;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.vid_req    = 1'b0;
        bus.vid_addr   = '0;
        bus.gm_req     = 1'b0;
        bus.gm_we      = 1'b0;
        bus.gm_addr    = '0;
        bus.gm_wdata   = '0;
        bus.fill_start = 1'b0;
        bus.fill_base  = '0;
        bus.fill_len   = '0;
        bus.fill_value = '0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        tick();
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        #4;
        vectors++; if (ram_en !== 1'b0) begin miscompares++; $display("FAIL reset ram_en got %b want 0", ram_en); end
        vectors++; if (bus.fill_busy !== 1'b0) begin miscompares++; $display("FAIL reset fill_busy got %b want 0", bus.fill_busy); end
        vectors++; if (bus.fill_done !== 1'b0) begin miscompares++; $display("FAIL reset fill_done got %b want 0", bus.fill_done); end
        vectors++; if ({bus.vid_rvalid, bus.gm_rvalid} !== 2'b00) begin miscompares++; $display("FAIL reset rvalids got %b want 00", {bus.vid_rvalid, bus.gm_rvalid}); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_video_read();
        preload(16'h0010, 8'h3C);
        tick();
        bus.vid_req = 1'b1; bus.vid_addr = 16'h0010;
        #4;
        vectors++; if ({ram_en, ram_we} !== 2'b10) begin miscompares++; $display("FAIL vid_issue en/we got %b want 10", {ram_en, ram_we}); end
        vectors++; if (ram_addr !== 16'h0010) begin miscompares++; $display("FAIL vid_issue addr got %h want 0010", ram_addr); end
        vectors++; if (bus.vid_miss !== 1'b0) begin miscompares++; $display("FAIL vid_issue miss got %b want 0", bus.vid_miss); end
        tick();
        bus.vid_req = 1'b0;
        #4;
        vectors++; if (bus.vid_rvalid !== 1'b1) begin miscompares++; $display("FAIL vid_ret rvalid got %b want 1", bus.vid_rvalid); end
        vectors++; if (bus.vid_rdata !== 8'h3C) begin miscompares++; $display("FAIL vid_ret rdata got %h want 3c", bus.vid_rdata); end
        vectors++; if (bus.gm_rvalid !== 1'b0) begin miscompares++; $display("FAIL vid_ret gm_rvalid got %b want 0", bus.gm_rvalid); end
        tick();
        #4;
        vectors++; if (bus.vid_rvalid !== 1'b0) begin miscompares++; $display("FAIL vid_after rvalid got %b want 0", bus.vid_rvalid); end
    endtask

    task automatic test_game_rw();
        tick();
        bus.gm_req = 1'b1; bus.gm_we = 1'b1; bus.gm_addr = 16'h1234; bus.gm_wdata = 8'hA5;
        #4;
        vectors++; if (bus.gm_gnt !== 1'b1) begin miscompares++; $display("FAIL gm_wr gnt got %b want 1", bus.gm_gnt); end
        vectors++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, 16'h1234, 8'hA5}) begin
            miscompares++; $display("FAIL gm_wr port got %b%b %h %h want 11 1234 a5", ram_en, ram_we, ram_addr, ram_wdata); end
        tick();
        bus.gm_we = 1'b0;
        #4;
        vectors++; if (bus.gm_rvalid !== 1'b0) begin miscompares++; $display("FAIL gm_wr rvalid got %b want 0", bus.gm_rvalid); end
        vectors++; if ({bus.gm_gnt, ram_we} !== 2'b10) begin miscompares++; $display("FAIL gm_rd gnt/we got %b want 10", {bus.gm_gnt, ram_we}); end
        tick();
        bus.gm_req = 1'b0;
        #4;
        vectors++; if (bus.gm_rvalid !== 1'b1) begin miscompares++; $display("FAIL gm_rd rvalid got %b want 1", bus.gm_rvalid); end
        vectors++; if (bus.gm_rdata !== 8'hA5) begin miscompares++; $display("FAIL gm_rd rdata got %h want a5", bus.gm_rdata); end
        vectors++; if (bus.vid_rvalid !== 1'b0) begin miscompares++; $display("FAIL gm_rd vid_rvalid got %b want 0", bus.vid_rvalid); end
        tick();
        idle_inputs();
    endtask

    task automatic test_starvation();
        logic prev_gnt;
        prev_gnt = 1'b0;
        tick();
        bus.vid_req = 1'b1; bus.vid_addr = 16'h0010;
        bus.gm_req  = 1'b1; bus.gm_we = 1'b0; bus.gm_addr = 16'h1234;
        for (int i = 0; i < 18; i++) begin
            logic exp_gnt;
            exp_gnt = (i == 8) || (i == 17);
            #4;
            vectors++; if (bus.gm_gnt !== exp_gnt) begin miscompares++; $display("FAIL starve cyc %0d gnt got %b want %b", i, bus.gm_gnt, exp_gnt); end
            vectors++; if (bus.vid_miss !== exp_gnt) begin miscompares++; $display("FAIL starve cyc %0d vid_miss got %b want %b", i, bus.vid_miss, exp_gnt); end
            vectors++; if (ram_addr !== (exp_gnt ? 16'h1234 : 16'h0010)) begin miscompares++; $display("FAIL starve cyc %0d addr got %h", i, ram_addr); end
            if (i > 0) begin
                vectors++; if ({bus.vid_rvalid, bus.gm_rvalid} !== {!prev_gnt, prev_gnt}) begin
                    miscompares++; $display("FAIL starve cyc %0d rvalids got %b%b want %b%b", i, bus.vid_rvalid, bus.gm_rvalid, !prev_gnt, prev_gnt); end
            end
            prev_gnt = exp_gnt;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_fill_wrap();
        logic [15:0] exp_a [4];
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        preload(16'hFFFF, 8'h99);
        preload(16'h0000, 8'h99);
        tick();
        bus.fill_start = 1'b1; bus.fill_base = 16'hFFFE; bus.fill_len = 17'd4; bus.fill_value = 8'h00;
        #4;
        vectors++; if (ram_en !== 1'b0) begin miscompares++; $display("FAIL wrap start ram_en got %b want 0", ram_en); end
        tick();
        bus.fill_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #4;
            vectors++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, exp_a[i], 8'h00}) begin
                miscompares++; $display("FAIL wrap wr %0d got %b%b %h %h want 11 %h 00", i, ram_en, ram_we, ram_addr, ram_wdata, exp_a[i]); end
            vectors++; if ({bus.fill_busy, bus.fill_done} !== 2'b10) begin miscompares++; $display("FAIL wrap wr %0d busy/done got %b want 10", i, {bus.fill_busy, bus.fill_done}); end
            tick();
        end
        #4;
        vectors++; if ({bus.fill_busy, bus.fill_done, ram_en} !== 3'b010) begin miscompares++; $display("FAIL wrap done busy/done/en got %b want 010", {bus.fill_busy, bus.fill_done, ram_en}); end
        tick();
        #4;
        vectors++; if ({bus.fill_done, ram_en} !== 2'b00) begin miscompares++; $display("FAIL wrap after done/en got %b want 00", {bus.fill_done, ram_en}); end
        vectors++; if ({mem[16'hFFFF], mem[16'h0000]} !== 16'h0000) begin miscompares++; $display("FAIL wrap mem got %h want 0000", {mem[16'hFFFF], mem[16'h0000]}); end
    endtask

    task automatic test_fill_stall();
        tick();
        bus.fill_start = 1'b1; bus.fill_base = 16'h0100; bus.fill_len = 17'd3; bus.fill_value = 8'h5A;
        tick();
        bus.fill_start = 1'b0;
        for (int j = 0; j < 6; j++) begin
            bus.vid_req    = (j % 2 == 0);
            bus.vid_addr   = 16'h0040;
            bus.fill_start = (j == 2);
            bus.fill_base  = 16'h0200;
            bus.fill_len   = 17'd1;
            #4;
            if (j % 2 == 0) begin
                vectors++; if ({ram_we, ram_addr, bus.vid_miss} !== {1'b0, 16'h0040, 1'b0}) begin
                    miscompares++; $display("FAIL stall cyc %0d got we %b addr %h miss %b want 0 0040 0", j, ram_we, ram_addr, bus.vid_miss); end
            end else begin
                vectors++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, 16'h0100 + 16'(j / 2), 8'h5A}) begin
                    miscompares++; $display("FAIL stall cyc %0d wr got %b%b %h %h want 11 %h 5a", j, ram_en, ram_we, ram_addr, ram_wdata, 16'h0100 + 16'(j / 2)); end
            end
            tick();
        end
        idle_inputs();
        #4;
        vectors++; if ({bus.fill_done, bus.fill_busy, ram_en} !== 3'b100) begin miscompares++; $display("FAIL stall done done/busy/en got %b want 100", {bus.fill_done, bus.fill_busy, ram_en}); end
        tick();
        #4;
        vectors++; if ({bus.fill_done, bus.fill_busy, ram_en} !== 3'b000) begin miscompares++; $display("FAIL stall ignored_start done/busy/en got %b want 000", {bus.fill_done, bus.fill_busy, ram_en}); end
    endtask

    task automatic test_fill_len0();
        tick();
        bus.fill_start = 1'b1; bus.fill_base = 16'h0500; bus.fill_len = 17'd0; bus.fill_value = 8'hEE;
        #4;
        vectors++; if (ram_en !== 1'b0) begin miscompares++; $display("FAIL len0 start ram_en got %b want 0", ram_en); end
        tick();
        bus.fill_start = 1'b0;
        #4;
        vectors++; if ({bus.fill_done, bus.fill_busy, ram_en} !== 3'b100) begin miscompares++; $display("FAIL len0 done done/busy/en got %b want 100", {bus.fill_done, bus.fill_busy, ram_en}); end
        tick();
        #4;
        vectors++; if ({bus.fill_done, ram_en} !== 2'b00) begin miscompares++; $display("FAIL len0 after done/en got %b want 00", {bus.fill_done, ram_en}); end
    endtask

    task automatic test_reset_mid_fill();
        tick();
        bus.fill_start = 1'b1; bus.fill_base = 16'h0300; bus.fill_len = 17'd10; bus.fill_value = 8'h77;
        tick();
        bus.fill_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #4;
            vectors++; if ({ram_we, ram_addr} !== {1'b1, 16'h0300 + 16'(i)}) begin miscompares++; $display("FAIL rstfill wr %0d got %b %h", i, ram_we, ram_addr); end
            tick();
        end
        bus.vid_req = 1'b1; bus.vid_addr = 16'h0010;
        tick();
        bus.vid_req = 1'b0;
        reset = 1'b1;
        #1;
        vectors++; if ({bus.fill_busy, bus.fill_done, ram_en, bus.vid_rvalid} !== 4'b0000) begin
            miscompares++; $display("FAIL rstfill assert busy/done/en/vrv got %b want 0000", {bus.fill_busy, bus.fill_done, ram_en, bus.vid_rvalid}); end
        tick();
        #4;
        vectors++; if ({bus.fill_busy, bus.fill_done} !== 2'b00) begin miscompares++; $display("FAIL rstfill held busy/done got %b want 00", {bus.fill_busy, bus.fill_done}); end
        tick();
        reset = 1'b0;
        #4;
        vectors++; if ({bus.fill_busy, bus.fill_done, ram_en} !== 3'b000) begin miscompares++; $display("FAIL rstfill release got %b want 000", {bus.fill_busy, bus.fill_done, ram_en}); end
        vectors++; if ({mem[16'h0300], mem[16'h0301]} !== 16'h7777) begin miscompares++; $display("FAIL rstfill mem got %h want 7777", {mem[16'h0300], mem[16'h0301]}); end
        tick();
        bus.fill_start = 1'b1; bus.fill_base = 16'h0400; bus.fill_len = 17'd2; bus.fill_value = 8'h11;
        tick();
        bus.fill_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #4;
            vectors++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, 16'h0400 + 16'(i), 8'h11}) begin
                miscompares++; $display("FAIL refill wr %0d got %b%b %h %h", i, ram_en, ram_we, ram_addr, ram_wdata); end
            tick();
        end
        #4;
        vectors++; if ({bus.fill_done, bus.fill_busy} !== 2'b10) begin miscompares++; $display("FAIL refill done/busy got %b want 10", {bus.fill_done, bus.fill_busy}); end
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_video_read();
        test_game_rw();
        test_starvation();
        test_fill_wrap();
        test_fill_stall();
        test_fill_len0();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
